// File: rtl/card_board_cursor.sv
// card_board_cursor
//   Holds the 16-slot memory-match board, turns debounced buttons into a
//   4x4 grid cursor plus a filtered card-select handshake, and serves a
//   registered read port for the display renderer.
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   WriteEnable         board write strobe from gameplay
//   dataLoc[3:0]        slot written, {row, col}
//   dataOut[5:0]        slot contents {status, value}
//                       status: 00 face-up, 01 hidden, 10 removed, 11 reserved
//   BtnUp/Down/Left/Right, BtnCenter   debounced level buttons
//   Select              card-select level to gameplay
//   CardSelectLoc[3:0]  slot of the selected card
//   CardSelectData[5:0] board contents of that slot at selection time
//   Cursor[3:0]         current cursor slot
//   RdLoc[3:0]          display read address
//   RdData[5:0]         display read data (1-cycle latency, no write bypass)
//
// Build option:
//   CURSOR_SKIP_REMOVED_EN  when defined, a move steps over removed slots
//                           (up to 3 positions); otherwise every move is one step.
module card_board_cursor (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       WriteEnable,
  input  logic [3:0] dataLoc,
  input  logic [5:0] dataOut,
  input  logic       BtnUp,
  input  logic       BtnDown,
  input  logic       BtnLeft,
  input  logic       BtnRight,
  input  logic       BtnCenter,
  output logic       Select,
  output logic [3:0] CardSelectLoc,
  output logic [5:0] CardSelectData,
  output logic [3:0] Cursor,
  input  logic [3:0] RdLoc,
  output logic [5:0] RdData
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] STATUS_HIDDEN  = 2'b01;
  localparam logic [1:0] STATUS_REMOVED = 2'b10;

  logic [5:0] board [16];
  logic [0:0] state;

  // Button vector order: {center, right, left, down, up}
  logic [4:0] btn_now;
  logic [4:0] btn_prev;
  logic [4:0] btn_rise;

  logic [5:0] eff_data;
  logic       sel_ok;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] next_cursor;

  assign btn_now  = {BtnCenter, BtnRight, BtnLeft, BtnDown, BtnUp};
  assign btn_rise = btn_now & ~btn_prev;

  // Step n positions from loc in dir; 2-bit row/col arithmetic wraps mod 4.
  function automatic logic [3:0] step_pos(input logic [3:0] loc,
                                          input logic [1:0] dir,
                                          input logic [1:0] n);
    logic [1:0] row;
    logic [1:0] col;
    row = loc[3:2];
    col = loc[1:0];
    case (dir)
      DIR_UP:    row = row - n;
      DIR_DOWN:  row = row + n;
      DIR_LEFT:  col = col - n;
      default:   col = col + n;
    endcase
    return {row, col};
  endfunction

  // A write landing on the cursor slot in the same cycle is what gets selected.
  always_comb begin
    eff_data = board[Cursor];
    if (WriteEnable && (dataLoc == Cursor)) begin
      eff_data = dataOut;
    end
  end

  assign sel_ok = (state == ST_IDLE) && btn_rise[4] && (eff_data[5:4] == STATUS_HIDDEN);

  // A center edge swallows any coincident direction edge, selected or not.
  always_comb begin
    move_valid = 1'b0;
    move_dir   = DIR_UP;
    if ((state == ST_IDLE) && !btn_rise[4]) begin
      if (btn_rise[0]) begin
        move_valid = 1'b1;
        move_dir   = DIR_UP;
      end else if (btn_rise[1]) begin
        move_valid = 1'b1;
        move_dir   = DIR_DOWN;
      end else if (btn_rise[2]) begin
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
      end else if (btn_rise[3]) begin
        move_valid = 1'b1;
        move_dir   = DIR_RIGHT;
      end
    end
  end

`ifdef CURSOR_SKIP_REMOVED_EN
  logic [3:0] cand;
  logic       found;

  // Candidates are checked against stored contents; first non-removed wins.
  always_comb begin
    next_cursor = Cursor;
    cand        = Cursor;
    found       = 1'b0;
    if (move_valid) begin
      for (int unsigned n = 1; n <= 3; n++) begin
        cand = step_pos(Cursor, move_dir, n[1:0]);
        if (!found && (board[cand][5:4] != STATUS_REMOVED)) begin
          next_cursor = cand;
          found       = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    next_cursor = Cursor;
    if (move_valid) begin
      next_cursor = step_pos(Cursor, move_dir, 2'd1);
    end
  end
`endif

  // Board storage and display read port
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        board[i] <= '0;
      end
      RdData <= '0;
    end else begin
      if (WriteEnable) begin
        board[dataLoc] <= dataOut;
      end
      RdData <= board[RdLoc];
    end
  end

  // Edge history resets high so buttons held through reset do not fire.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_prev <= '1;
      Cursor   <= '0;
    end else begin
      btn_prev <= btn_now;
      Cursor   <= next_cursor;
    end
  end

  // Select handshake
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= ST_IDLE;
      Select         <= 1'b0;
      CardSelectLoc  <= '0;
      CardSelectData <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (sel_ok) begin
          state          <= ST_HOLD;
          Select         <= 1'b1;
          CardSelectLoc  <= Cursor;
          CardSelectData <= eff_data;
        end
      end else begin
        if (!BtnCenter) begin
          state  <= ST_IDLE;
          Select <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_card_board_cursor.sv
// Testbench for card_board_cursor: directed stimulus with a scoreboard of
// expected select handshakes checked by an independent monitor.
module tb_card_board_cursor;

  logic       Clk;
  logic       Reset;
  logic       WriteEnable;
  logic [3:0] dataLoc;
  logic [5:0] dataOut;
  logic       BtnUp, BtnDown, BtnLeft, BtnRight, BtnCenter;
  logic       Select;
  logic [3:0] CardSelectLoc;
  logic [5:0] CardSelectData;
  logic [3:0] Cursor;
  logic [3:0] RdLoc;
  logic [5:0] RdData;

  card_board_cursor dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .WriteEnable   (WriteEnable),
    .dataLoc       (dataLoc),
    .dataOut       (dataOut),
    .BtnUp         (BtnUp),
    .BtnDown       (BtnDown),
    .BtnLeft       (BtnLeft),
    .BtnRight      (BtnRight),
    .BtnCenter     (BtnCenter),
    .Select        (Select),
    .CardSelectLoc (CardSelectLoc),
    .CardSelectData(CardSelectData),
    .Cursor        (Cursor),
    .RdLoc         (RdLoc),
    .RdData        (RdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] loc;
    logic [5:0] data;
    int         len;
  } sel_t;

  sel_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_UP:    BtnUp    = v;
      B_DOWN:  BtnDown  = v;
      B_LEFT:  BtnLeft  = v;
      default: BtnRight = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick();
    set_btn(which, 1'b0);
    tick();
  endtask

  task automatic write_slot(input logic [3:0] loc, input logic [5:0] d);
    WriteEnable = 1'b1;
    dataLoc     = loc;
    dataOut     = d;
    tick();
    WriteEnable = 1'b0;
  endtask

  // Monitor: pops an expected handshake at every Select rise, checks its
  // payload, then checks how many sampled cycles Select stayed high.
  logic cur_sel_prev = 1'b0;
  int   hi_len = 0;
  int   want_len = 0;
  always @(negedge Clk) begin
    if (Select && !cur_sel_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_select: got loc %0h data %0h, expected no select",
                 CardSelectLoc, CardSelectData);
        want_len = -1;
      end else begin
        sel_t e;
        e = exp_q.pop_front();
        chk("select_loc", CardSelectLoc, e.loc);
        chk("select_data", CardSelectData, e.data);
        want_len = e.len;
      end
      hi_len = 1;
    end else if (Select) begin
      hi_len++;
    end else if (cur_sel_prev && want_len >= 0) begin
      chk("select_high_cycles", hi_len, want_len);
    end
    cur_sel_prev = Select;
  end

  initial begin
    Reset = 1'b1; WriteEnable = 1'b0; dataLoc = '0; dataOut = '0;
    BtnUp = 0; BtnDown = 0; BtnLeft = 0; BtnRight = 1'b1; BtnCenter = 0;
    RdLoc = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick(); tick();
    chk("reset_cursor_right_held", Cursor, 0);
    chk("reset_select", Select, 0);
    chk("reset_sel_loc", CardSelectLoc, 0);
    chk("reset_sel_data", CardSelectData, 0);
    chk("reset_rddata", RdData, 0);
    BtnRight = 1'b0;
    tick();
    press(B_RIGHT);
    chk("cursor_right_1", Cursor, 1);
    repeat (3) press(B_RIGHT);
    chk("cursor_right_wrap", Cursor, 0);
    press(B_LEFT);
    chk("cursor_left_wrap", Cursor, 3);
    press(B_RIGHT);
    chk("cursor_right_back", Cursor, 0);
    press(B_UP);
    chk("cursor_up_wrap", Cursor, 12);
    press(B_DOWN);
    chk("cursor_down_wrap", Cursor, 0);

    // Fill board with hidden cards {01, loc>>1}
    for (int i = 0; i < 16; i++) begin
      logic [3:0] l;
      logic [3:0] v;
      l = 4'(i);
      v = 4'(i >> 1);
      write_slot(l, {2'b01, v});
    end
    RdLoc = 4'd5;
    tick();
    chk("rd_slot5", RdData, 6'b010010);
    press(B_DOWN);
    press(B_RIGHT);
    chk("cursor_at_5", Cursor, 5);

    // Center held 4 cycles; a direction edge during HOLD is ignored
    exp_q.push_back('{loc: 4'd5, data: 6'b010010, len: 4});
    BtnCenter = 1'b1;
    tick();
    chk("select_latency", Select, 1);
    BtnUp = 1'b1;
    tick();
    BtnUp = 1'b0;
    tick();
    tick();
    BtnCenter = 1'b0;
    tick();
    chk("select_fell", Select, 0);
    chk("cursor_frozen_in_hold", Cursor, 5);
    chk("sel_data_held_idle", CardSelectData, 6'b010010);

    // Removed card: center edge ignored
    write_slot(4'd5, 6'b100010);
    BtnCenter = 1'b1;
    tick();
    chk("removed_no_select", Select, 0);
    BtnCenter = 1'b0;
    tick();
    chk("removed_still_idle", Select, 0);

    press(B_UP);
    press(B_RIGHT);
    press(B_RIGHT);
    chk("cursor_at_3", Cursor, 3);

    // Same-cycle write to cursor slot, center edge and up edge
    exp_q.push_back('{loc: 4'd3, data: 6'b010111, len: 2});
    WriteEnable = 1'b1; dataLoc = 4'd3; dataOut = 6'b010111;
    BtnCenter = 1'b1; BtnUp = 1'b1; RdLoc = 4'd3;
    tick();
    chk("bypass_select", Select, 1);
    chk("bypass_cursor_kept", Cursor, 3);
    chk("rd_old_value", RdData, 6'b010001);
    WriteEnable = 1'b0; BtnUp = 1'b0;
    tick();
    chk("rd_new_value", RdData, 6'b010111);
    BtnCenter = 1'b0;
    tick();
    chk("bypass_select_fell", Select, 0);

    // Reset in the middle of HOLD
    exp_q.push_back('{loc: 4'd3, data: 6'b010111, len: 1});
    BtnCenter = 1'b1;
    tick();
    chk("hold_before_reset", Select, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_select", Select, 0);
    chk("async_reset_cursor", Cursor, 0);
    chk("async_reset_rddata", RdData, 0);
    chk("async_reset_sel_loc", CardSelectLoc, 0);
    chk("async_reset_sel_data", CardSelectData, 0);
    tick();
    Reset = 1'b0;
    BtnCenter = 1'b0;
    for (int i = 0; i < 16; i++) begin
      RdLoc = 4'(i);
      tick();
      chk("board_cleared", RdData, 0);
    end

`ifdef CURSOR_SKIP_REMOVED_EN
    write_slot(4'd1, 6'b100000);
    write_slot(4'd2, 6'b100000);
    press(B_RIGHT);
    chk("skip_two_removed", Cursor, 3);
    press(B_RIGHT);
    chk("skip_wrap_to_0", Cursor, 0);
    write_slot(4'd3, 6'b100000);
    press(B_RIGHT);
    chk("skip_all_removed_stay", Cursor, 0);
`endif

    repeat (3) tick();
    chk("pending_selects", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
